// File: rtl/freq_gate_counter.sv
// Gate-window frequency counter: counts synchronised rising edges of signal_in over
// UPDATE_PERIOD clocks, then converts the saturated total to two BCD digits with a load strobe.
module freq_gate_counter #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int EDGE_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal_in,
  output logic [3:0] ten_count,
  output logic [3:0] unit_count,
  output logic       load,
  output logic       overflow
);

  localparam int                WIN_W     = $clog2(UPDATE_PERIOD);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(UPDATE_PERIOD - 1);
  localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [EDGE_W:0]   TOTAL_CAP = (EDGE_W + 1)'(99);

  typedef enum logic {
    S_COUNT,
    S_CONV
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [6:0]       work_q, work_d;
  logic [3:0]       tens_acc_q, tens_acc_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [3:0]       ten_count_q, ten_count_d;
  logic [3:0]       unit_count_q, unit_count_d;
  logic             load_q, load_d;
  logic             overflow_q, overflow_d;

  logic             edge_det;
  logic             at_t;
  logic [EDGE_W:0]  total;
  logic             total_over;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    sync1_d      = signal_in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    edge_det     = sync2_q & ~prev_q;

    at_t         = (win_cnt_q == WIN_LAST);
    win_cnt_d    = at_t ? '0 : win_cnt_q + WIN_ONE;

    // An edge seen in the closing cycle still belongs to the closing window.
    total        = {1'b0, edge_cnt_q} + {{EDGE_W{1'b0}}, edge_det};
    total_over   = (total > TOTAL_CAP);

    edge_cnt_d   = edge_cnt_q;
    if (at_t) begin
      edge_cnt_d = '0;
    end else if (edge_det && (edge_cnt_q != EDGE_MAX)) begin
      edge_cnt_d = edge_cnt_q + EDGE_ONE;
    end

    state_d      = state_q;
    work_d       = work_q;
    tens_acc_d   = tens_acc_q;
    ovf_pend_d   = ovf_pend_q;
    ten_count_d  = ten_count_q;
    unit_count_d = unit_count_q;
    overflow_d   = overflow_q;
    load_d       = 1'b0;

    unique case (state_q)
      S_COUNT: begin
        if (at_t) begin
          state_d    = S_CONV;
          work_d     = total_over ? 7'd99 : total[6:0];
          ovf_pend_d = total_over;
          tens_acc_d = 4'd0;
        end
      end
      S_CONV: begin
        // Repeated subtraction: one tens step per cycle, at most nine steps.
        if (work_q >= 7'd10) begin
          work_d     = work_q - 7'd10;
          tens_acc_d = tens_acc_q + 4'd1;
        end else begin
          ten_count_d  = tens_acc_q;
          unit_count_d = work_q[3:0];
          overflow_d   = ovf_pend_q;
          load_d       = 1'b1;
          state_d      = S_COUNT;
        end
      end
      default: state_d = S_COUNT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_COUNT;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      work_q       <= '0;
      tens_acc_q   <= '0;
      ovf_pend_q   <= 1'b0;
      ten_count_q  <= '0;
      unit_count_q <= '0;
      load_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      work_q       <= work_d;
      tens_acc_q   <= tens_acc_d;
      ovf_pend_q   <= ovf_pend_d;
      ten_count_q  <= ten_count_d;
      unit_count_q <= unit_count_d;
      load_q       <= load_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ten_count  = ten_count_q;
  assign unit_count = unit_count_q;
  assign load       = load_q;
  assign overflow   = overflow_q;

endmodule
